s27_lanes_scan: RTL
===================

Name: s27_lanes_scan

Overview:
- Parametrised multi-lane successor to the s27 sequential benchmark, used as a scalable test article for the EDA flow (ATPG, scan insertion, signature checks).
- Each lane runs the s27 3-flip-flop next-state/output function independently.
- Adds async active-low reset, a full scan chain, a MISR signature compactor on the lane outputs and a saturating capture counter.

Parameters:
- LANES, 4, number of independent s27 lanes (1..MISR_W).
- MISR_W, 16, signature register width.
- MISR_POLY, 16'hB400, Galois feedback mask (MISR_W bits).
- CNT_W, 16, capture counter width.

Ports:
- CK  input  1  clock, all state on rising edge.
- RN  input  1  asynchronous active-low reset.
- G0  input  LANES  per-lane primary input 0.
- G1  input  LANES  per-lane primary input 1.
- G2  input  LANES  per-lane primary input 2.
- G3  input  LANES  per-lane primary input 3.
- G17  output  LANES  per-lane primary output (combinational).
- SE  input  1  scan enable.
- SI  input  1  scan data in.
- SO  output  1  scan data out.
- CAP_EN  input  1  functional cycle feeds MISR and counter.
- MCLR  input  1  synchronous clear of MISR and counter.
- SIG  output  MISR_W  MISR signature.
- CAP_CNT  output  CNT_W  number of captured cycles, saturating.

Behaviour:
- Per lane i, state bits s5, s6, s7 and inputs g0..g3 are G0[i]..G3[i].
- Lane logic:
  - n14 = ~g0; n8 = n14 & s6.
  - n12 = ~(g1 | s7); n15 = n12 | n8; n16 = g3 | n8.
  - n9 = ~(n16 & n15); n11 = ~(s5 | n9).
  - n10 = ~(n14 | n11); n13 = ~(g2 | n12).
  - G17[i] = ~n11.
- Functional mode (SE=0): s5 <= n10, s6 <= n11, s7 <= n13 every cycle, all lanes in parallel.
- Scan mode (SE=1): functional update suppressed. Chain order is SI -> lane0.s5 -> lane0.s6 -> lane0.s7 -> lane1.s5 -> ... -> lane(LANES-1).s7 -> SO.
  - Chain length is 3*LANES.
  - One bit shifts per cycle.
  - SO is the registered last chain bit, valid in both modes.
- MISR updates only when SE=0 and CAP_EN=1 and MCLR=0:
  - fb = SIG[0].
  - SIG <= (SIG >> 1) ^ (fb ? MISR_POLY : 0) ^ zero_extend(G17).
  - Otherwise SIG holds.
- CAP_CNT increments on the same condition and saturates at all-ones (no wrap).
- MCLR=1: SIG and CAP_CNT go to 0 next edge. MCLR has priority over capture and does not affect lane state or the scan chain.
- SE=1 with CAP_EN=1: no capture; SIG and CAP_CNT hold.
- Reset (RN=0, asynchronous, any time including mid-shift or mid-capture):
  - All lane state, SIG and CAP_CNT = 0 immediately; SO = 0.
  - G17 remains the combinational function of inputs with state 000.
  - Release is synchronous to CK; the first update is at the first rising edge with RN=1.
- G17 has zero latency from inputs/state. Next state and SIG reflect inputs at the capturing edge.
- Elaboration error if LANES > MISR_W or LANES < 1.

Test Plan:
- Reset/idle: RN pulse low mid-cycle, all G*=0, SE=0 -> state 000 in all lanes, G17=4'b1111, SO=0, SIG=0, CAP_CNT=0; one clock -> state remains 000.
- Functional: lane0 G0=1,G3=1, G1=G2=0 from state 000 -> G17[0]=0, next state (s5,s6,s7)=(0,1,0). Then G0=0 -> G17[0]=0, state stays 010.
- Scan: SE=1, shift 12 bits 101100111000 -> readback over 12 further shifts reproduces the sequence on SO, delayed 12 cycles. Lane state is unchanged by G* during the shift.
- MISR: after reset, CAP_EN=1 with G17=4'b1111 -> SIG=16'h000F, CAP_CNT=1. Next capture with G17=0000 -> SIG=16'hB407, CAP_CNT=2.
- Priority/saturation: MCLR=1 with CAP_EN=1 -> SIG=0, CAP_CNT=0. With CNT_W=4, 20 captures -> CAP_CNT=15. SE=1 with CAP_EN=1 -> SIG and CAP_CNT unchanged.
- Async reset mid-shift: RN low after 5 scan shifts -> chain cleared at once; after release, 12 shifts of zeros on SI -> SO stays 0.

Source files
------------

// File: rtl/s27_lanes_scan.sv
// Multi-lane s27 sequential benchmark with a full scan chain, a Galois MISR
// over the lane outputs and a saturating capture counter.
module s27_lanes_scan #(
  parameter int                LANES     = 4,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'hB400,
  parameter int                CNT_W     = 16
) (
  input  logic              CK,
  input  logic              RN,
  input  logic [LANES-1:0]  G0,
  input  logic [LANES-1:0]  G1,
  input  logic [LANES-1:0]  G2,
  input  logic [LANES-1:0]  G3,
  output logic [LANES-1:0]  G17,
  input  logic              SE,
  input  logic              SI,
  output logic              SO,
  input  logic              CAP_EN,
  input  logic              MCLR,
  output logic [MISR_W-1:0] SIG,
  output logic [CNT_W-1:0]  CAP_CNT
);

  localparam int CHAIN_W = 3 * LANES;

  if (LANES < 1 || LANES > MISR_W) begin : g_bad_lanes
    $error("s27_lanes_scan: LANES must be in 1..MISR_W");
  end

  // Lane i owns chain bits 3i (s5), 3i+1 (s6), 3i+2 (s7); bit 0 is nearest SI.
  logic [CHAIN_W-1:0] chain_q, chain_d, func_d;
  logic [MISR_W-1:0]  sig_q, sig_d, g17_ext;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               capture;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic s5, s6, s7;
    logic n8, n9, n10, n11, n12, n13, n14, n15, n16;

    assign s5  = chain_q[3*i];
    assign s6  = chain_q[3*i+1];
    assign s7  = chain_q[3*i+2];

    assign n14 = ~G0[i];
    assign n8  = n14 & s6;
    assign n12 = ~(G1[i] | s7);
    assign n15 = n12 | n8;
    assign n16 = G3[i] | n8;
    assign n9  = ~(n16 & n15);
    assign n11 = ~(s5 | n9);
    assign n10 = ~(n14 | n11);
    assign n13 = ~(G2[i] | n12);

    assign G17[i]         = ~n11;
    assign func_d[3*i]    = n10;
    assign func_d[3*i+1]  = n11;
    assign func_d[3*i+2]  = n13;
  end

  assign capture = ~SE & CAP_EN & ~MCLR;

  always_comb begin
    chain_d = func_d;
    if (SE) begin
      chain_d = {chain_q[CHAIN_W-2:0], SI};
    end
  end

  always_comb begin
    g17_ext              = '0;
    g17_ext[LANES-1:0]   = G17;
    sig_d                = sig_q;
    cnt_d                = cnt_q;
    if (MCLR) begin
      sig_d = '0;
      cnt_d = '0;
    end else if (capture) begin
      sig_d = (sig_q >> 1) ^ (sig_q[0] ? MISR_POLY : '0) ^ g17_ext;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      chain_q <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
    end else begin
      chain_q <= chain_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SO      = chain_q[CHAIN_W-1];
  assign SIG     = sig_q;
  assign CAP_CNT = cnt_q;

endmodule
